pipeline_hazard_unit: RTL and testbench
=======================================

Name: pipeline_hazard_unit

Overview:
- Central stall/flush/forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Replaces the single shared hit line with:
  - separate instruction-side and data-side miss handling,
  - load-use interlock,
  - taken-branch flush,
  - EX operand forwarding,
  - miss timeout detection,
  - a stall performance counter.
- Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- REG_ADDR_W, 5: register index width.
- MISS_TIMEOUT, 64: maximum number of cycles a miss may stay outstanding before an error is flagged. Range 2..2^16-1.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clock in 1: rising-edge clock.
- reset in 1: asynchronous, active-high reset.
- imem_hit in 1: instruction fetch data valid this cycle.
- dmem_hit in 1: data memory access complete. Only meaningful when mem_access=1.
- mem_access in 1: MEM stage holds a load or store.
- id_rs, id_rt in REG_ADDR_W: source registers in ID.
- id_uses_rs, id_uses_rt in 1: ID instruction reads that source.
- ex_rs, ex_rt in REG_ADDR_W: source registers in EX.
- ex_mem_read in 1: EX instruction is a load.
- ex_write_reg in REG_ADDR_W: destination register of the EX instruction.
- mem_reg_write in 1: MEM instruction writes the register file.
- mem_write_reg in REG_ADDR_W: destination register of the MEM instruction.
- wb_reg_write in 1: WB instruction writes the register file.
- wb_write_reg in REG_ADDR_W: destination register of the WB instruction.
- branch_taken in 1: resolved taken branch in MEM.
- pc_en out 1: PC update enable.
- ifid_en out 1: IF/ID register enable.
- idex_en out 1: ID/EX register enable.
- exmem_en out 1: EX/MEM register enable.
- memwb_en out 1: MEM/WB register enable.
- ifid_flush, idex_flush, exmem_flush out 1: load a bubble into that register.
- fwd_a, fwd_b out 2: operand select for EX. 00 = register file, 01 = WB value, 10 = MEM value.
- imem_abort out 1: one-cycle pulse; cancel the outstanding fetch.
- miss_error out 1: sticky; a miss exceeded MISS_TIMEOUT.
- stall_cycles out CNT_W: saturating count of cycles with pc_en=0.

Behaviour:
- Reset (asynchronous, active-high):
  - state=RUN, wait counter=0, miss_error=0, stall_cycles=0.
  - While reset is held, outputs are: all *_en=1, all flushes=0, fwd_a=fwd_b=00, imem_abort=0.
- States:
  - RUN: normal operation.
  - IMISS: waiting on the instruction fetch.
  - DMISS: waiting on the data access.
- Priority each cycle, highest first: DMISS/dmem miss > branch_taken > load-use > imem miss.
- Data miss (mem_access=1 && dmem_hit=0):
  - Asserted in the same cycle, combinationally: all five enables=0, no flushes.
  - Enter or stay in DMISS.
  - On the dmem_hit=1 cycle: enables=1 and state returns to RUN on the next edge.
- Taken branch (not in a data miss):
  - Assert ifid_flush, idex_flush, exmem_flush; pc_en=1 (loads the target).
  - If state was IMISS: pulse imem_abort and go to RUN.
  - A branch held during DMISS is frozen in MEM and is flushed in the cycle the miss completes.
- Load-use:
  - Condition: ex_mem_read && ex_write_reg!=0 && ((id_uses_rs && id_rs==ex_write_reg) || (id_uses_rt && id_rt==ex_write_reg)).
  - Response: pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle; state stays RUN.
- Instruction miss (imem_hit=0 with no higher-priority event):
  - pc_en=0, ifid_en=0, idex_flush=1 so the back end drains.
  - Enter or stay in IMISS; leave on the first imem_hit=1 cycle (normal enables in that cycle).
- Wait counter:
  - Cleared on entering IMISS or DMISS; increments each cycle in those states.
  - On reaching MISS_TIMEOUT: set miss_error. Only reset clears it. The state does not change.
- Forwarding (combinational):
  - fwd_a=10 if mem_reg_write && mem_write_reg!=0 && mem_write_reg==ex_rs.
  - Otherwise fwd_a=01 if the same test passes against the WB stage.
  - Otherwise fwd_a=00.
  - fwd_b is identical, using ex_rt.
  - MEM wins over WB. Register 0 is never forwarded.
- stall_cycles increments on every cycle with pc_en=0 (the branch flush cycle does not count). Saturates at all-ones.
- Reset asserted mid-miss: immediate return to RUN, counters cleared, no imem_abort pulse.

Decomposition:
- Shared package hazard_pkg:
  - state enum (RUN, IMISS, DMISS),
  - forward select constants (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
- One sub-module, forward_unit: the purely combinational fwd_a/fwd_b logic, instantiated once.

Test Plan:
- Load-use: lw $2 in EX with ex_write_reg=2, id_rs=2, id_uses_rs=1 → exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cycles goes 0→1.
- Forwarding:
  - mem_write_reg=3 and wb_write_reg=3, both writing, ex_rs=3 → fwd_a=10.
  - Same with ex_rs=0 and both destinations 0 → fwd_a=00.
- Instruction miss: imem_hit=0 for 3 cycles → IMISS, pc_en=0 for 3 cycles, stall_cycles=3; hit on cycle 4 → RUN.
- Branch during IMISS: branch_taken=1 on the 2nd miss cycle → imem_abort pulses for 1 cycle, three flushes asserted, RUN next edge.
- Data miss with branch: mem_access=1, dmem_hit=0 for 5 cycles with branch_taken=1 → all enables 0 and no flushes for 5 cycles; flushes asserted on the hit cycle.
- Timeout and reset: MISS_TIMEOUT=4, dmem_hit held 0 → miss_error=1 after 4 cycles and stays set; asserting reset mid-miss → RUN, miss_error=0, stall_cycles=0, before the next clock edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hazardState_t : controller state (RUN, IMISS, DMISS)
//   FWD_*         : EX operand source selects used by fwd_a/fwd_b
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMISS = 2'd1,
        DMISS = 2'd2
    } hazardState_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_hazard_unit_forward_unit.sv
// EX operand forwarding select, purely combinational.
//   ex_rs, ex_rt                 : EX source registers
//   mem_reg_write, mem_write_reg : MEM stage destination
//   wb_reg_write, wb_write_reg   : WB stage destination
//   fwd_a, fwd_b                 : operand source select (FWD_RF/FWD_WB/FWD_MEM)
module forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_write_reg,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    // Register 0 is hardwired to zero, so a write to it never forwards.
    logic memWrites;
    logic wbWrites;

    assign memWrites = mem_reg_write && (mem_write_reg != '0);
    assign wbWrites  = wb_reg_write  && (wb_write_reg  != '0);

    // MEM holds the younger result, so it takes precedence over WB.
    assign fwd_a = (memWrites && mem_write_reg == ex_rs) ? FWD_MEM :
                   (wbWrites  && wb_write_reg  == ex_rs) ? FWD_WB  : FWD_RF;
    assign fwd_b = (memWrites && mem_write_reg == ex_rt) ? FWD_MEM :
                   (wbWrites  && wb_write_reg  == ex_rt) ? FWD_WB  : FWD_RF;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   imem_hit, dmem_hit  : fetch / data access completion
//   mem_access          : MEM stage holds a load or store
//   id_*, ex_*          : register usage of the ID and EX instructions
//   mem_*, wb_*         : destinations of the MEM and WB instructions
//   branch_taken        : resolved taken branch in MEM
//   *_en, *_flush       : pipeline register enables and bubble inserts
//   fwd_a, fwd_b        : EX operand source selects
//   imem_abort          : one-cycle cancel of the outstanding fetch
//   miss_error          : sticky, a miss exceeded MISS_TIMEOUT cycles
//   stall_cycles        : saturating count of cycles with pc_en low
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int MISS_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  imem_hit,
    input  logic                  dmem_hit,
    input  logic                  mem_access,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_write_reg,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic                  branch_taken,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  imem_abort,
    output logic                  miss_error,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [15:0] TIMEOUT = 16'(MISS_TIMEOUT);

    hazardState_t state;
    hazardState_t nextState;
    logic [15:0]  waitCount;
    logic         dataMiss;
    logic         loadUse;
    logic [1:0]   fwdARaw;
    logic [1:0]   fwdBRaw;

    forward_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) forwardUnit (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_reg_write(mem_reg_write),
        .mem_write_reg(mem_write_reg),
        .wb_reg_write (wb_reg_write),
        .wb_write_reg (wb_write_reg),
        .fwd_a        (fwdARaw),
        .fwd_b        (fwdBRaw)
    );

    assign fwd_a = reset ? FWD_RF : fwdARaw;
    assign fwd_b = reset ? FWD_RF : fwdBRaw;

    assign dataMiss = mem_access && !dmem_hit;
    assign loadUse  = ex_mem_read && (ex_write_reg != '0) &&
                      ((id_uses_rs && id_rs == ex_write_reg) ||
                       (id_uses_rt && id_rt == ex_write_reg));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        imem_abort  = 1'b0;
        nextState   = RUN;
        if (dataMiss) begin
            // Freeze everything; a taken branch stays parked in MEM until the hit.
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            nextState = DMISS;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            imem_abort  = (state == IMISS);
            nextState   = RUN;
        end else if (loadUse || !imem_hit) begin
            // Hold the front end and drain a bubble into EX. A load-use stall
            // overlapping a pending fetch still leaves that fetch outstanding.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            nextState  = imem_hit ? RUN : IMISS;
        end
        if (reset) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            imem_abort  = 1'b0;
            nextState   = RUN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            waitCount    <= '0;
            miss_error   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= nextState;
            // The counter restarts on every entry into a miss state and only
            // advances while the same miss persists; it parks at TIMEOUT.
            if (nextState != RUN && nextState != state) begin
                waitCount <= '0;
            end else if (nextState != RUN && waitCount != TIMEOUT) begin
                waitCount <= waitCount + 16'd1;
                if (waitCount + 16'd1 == TIMEOUT) begin
                    miss_error <= 1'b1;
                end
            end
            if (!pc_en && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;

    localparam int RW  = 5;
    localparam int TO  = 4;
    localparam int CW  = 6;
    localparam int SAT = (1 << CW) - 1;

    typedef struct {
        bit          rst;
        bit          ih, dh, ma;
        bit [RW-1:0] idRs, idRt;
        bit          usesRs, usesRt;
        bit [RW-1:0] exRs, exRt;
        bit          exMr;
        bit [RW-1:0] exWr;
        bit          memRw;
        bit [RW-1:0] memWr;
        bit          wbRw;
        bit [RW-1:0] wbWr;
        bit          br;
    } stim_t;

    typedef struct {
        bit [4:0] en;     // {pc, ifid, idex, exmem, memwb}
        bit [2:0] fl;     // {ifid, idex, exmem}
        bit [1:0] fa, fb;
        bit       abort;
        bit       err;
        int       stall;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic imem_hit, dmem_hit, mem_access;
    logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
    logic id_uses_rs, id_uses_rt, ex_mem_read, mem_reg_write, wb_reg_write, branch_taken;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, imem_abort, miss_error;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cycles;

    pipeline_hazard_unit #(
        .REG_ADDR_W(RW), .MISS_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .imem_hit(imem_hit), .dmem_hit(dmem_hit), .mem_access(mem_access),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .branch_taken(branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .imem_abort(imem_abort),
        .miss_error(miss_error), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    // Reference model: which kind of miss is outstanding (0 none, 1 fetch, 2 data),
    // how many cycles it has been waited on, the sticky error and the stall tally.
    int   mKind, mAge, mStall;
    bit   mErr;
    exp_t expQ[$];
    int   nPass, nTotal;

    function automatic bit [1:0] refFwd(input stim_t s, input bit [RW-1:0] src);
        if (s.memRw && s.memWr != 0 && s.memWr == src) return 2'b10;
        if (s.wbRw && s.wbWr != 0 && s.wbWr == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.ih = 1;
        s.dh = 1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        int   nxt;
        bit   lu;
        @(posedge clock);
        #1;
        reset = s.rst; imem_hit = s.ih; dmem_hit = s.dh; mem_access = s.ma;
        id_rs = s.idRs; id_rt = s.idRt; id_uses_rs = s.usesRs; id_uses_rt = s.usesRt;
        ex_rs = s.exRs; ex_rt = s.exRt; ex_mem_read = s.exMr; ex_write_reg = s.exWr;
        mem_reg_write = s.memRw; mem_write_reg = s.memWr;
        wb_reg_write = s.wbRw; wb_write_reg = s.wbWr; branch_taken = s.br;
        e = '{en: 5'b11111, fl: 3'b000, fa: 2'b00, fb: 2'b00, abort: 0, err: 0, stall: 0};
        if (s.rst) begin
            mKind = 0; mAge = 0; mErr = 0; mStall = 0;
        end else begin
            e.err   = mErr;
            e.stall = mStall;
            e.fa    = refFwd(s, s.exRs);
            e.fb    = refFwd(s, s.exRt);
            lu = s.exMr && s.exWr != 0 &&
                 ((s.usesRs && s.idRs == s.exWr) || (s.usesRt && s.idRt == s.exWr));
            if (s.ma && !s.dh) begin
                e.en = 5'b00000;
                nxt  = 2;
            end else if (s.br) begin
                e.fl    = 3'b111;
                e.abort = (mKind == 1);
                nxt     = 0;
            end else if (lu || !s.ih) begin
                e.en = 5'b00111;
                e.fl = 3'b010;
                nxt  = s.ih ? 0 : 1;
            end else begin
                nxt = 0;
            end
            if (nxt != 0 && nxt == mKind) begin
                if (mAge < TO) begin
                    mAge++;
                    if (mAge == TO) mErr = 1;
                end
            end else begin
                mAge = 0;
            end
            if (!e.en[4] && mStall < SAT) mStall++;
            mKind = nxt;
        end
        expQ.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        nTotal++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("enables", int'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), int'(e.en));
                check("flushes", int'({ifid_flush, idex_flush, exmem_flush}), int'(e.fl));
                check("fwd_a", int'(fwd_a), int'(e.fa));
                check("fwd_b", int'(fwd_b), int'(e.fb));
                check("imem_abort", int'(imem_abort), int'(e.abort));
                check("miss_error", int'(miss_error), int'(e.err));
                check("stall_cycles", int'(stall_cycles), e.stall);
            end
        end
    end

    initial begin
        stim_t s;
        nPass = 0; nTotal = 0;
        mKind = 0; mAge = 0; mErr = 0; mStall = 0;
        s = idle();
        reset = 1; imem_hit = 1; dmem_hit = 1; mem_access = 0;
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_mem_read = 0; ex_write_reg = 0;
        mem_reg_write = 0; mem_write_reg = 0; wb_reg_write = 0; wb_write_reg = 0;
        branch_taken = 0;

        // Reset held with live-looking inputs: outputs must stay at defaults.
        s = idle(); s.rst = 1; s.ih = 0; s.br = 1;
        repeat (2) drive(s);
        drive(idle());

        // Load-use on $2.
        s = idle(); s.exMr = 1; s.exWr = 2; s.idRs = 2; s.usesRs = 1;
        drive(s);
        drive(idle());

        // Forwarding: MEM beats WB; register 0 never forwards.
        s = idle(); s.memRw = 1; s.memWr = 3; s.wbRw = 1; s.wbWr = 3; s.exRs = 3; s.exRt = 3;
        drive(s);
        s.memWr = 0; s.wbWr = 0; s.exRs = 0; s.exRt = 0;
        drive(s);
        s = idle(); s.wbRw = 1; s.wbWr = 7; s.exRt = 7;
        drive(s);

        // Instruction miss for 3 cycles, then hit.
        s = idle(); s.ih = 0;
        repeat (3) drive(s);
        drive(idle());

        // Branch on the second fetch-miss cycle.
        s = idle(); s.ih = 0;
        drive(s);
        s.br = 1;
        drive(s);
        drive(idle());

        // Data miss with a branch parked in MEM, then the hit cycle.
        s = idle(); s.ma = 1; s.dh = 0; s.br = 1;
        repeat (5) drive(s);
        s.dh = 1;
        drive(s);
        drive(idle());

        // Data miss held past the timeout, then reset mid-miss.
        s = idle(); s.ma = 1; s.dh = 0;
        repeat (8) drive(s);
        s.rst = 1;
        drive(s);
        s.rst = 0;
        repeat (2) drive(s);
        drive(idle());

        // Randomized traffic, occasionally with long miss bursts and resets.
        for (int i = 0; i < 1500; i++) begin
            s = idle();
            s.rst    = ($urandom_range(0, 199) == 0);
            s.ih     = ($urandom_range(0, 5) != 0);
            s.ma     = ($urandom_range(0, 2) == 0);
            s.dh     = ((i / 100) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            s.br     = ($urandom_range(0, 9) == 0);
            s.idRs   = RW'($urandom_range(0, 3));
            s.idRt   = RW'($urandom_range(0, 3));
            s.usesRs = 1'($urandom);
            s.usesRt = 1'($urandom);
            s.exRs   = RW'($urandom_range(0, 3));
            s.exRt   = RW'($urandom_range(0, 3));
            s.exMr   = ($urandom_range(0, 2) == 0);
            s.exWr   = RW'($urandom_range(0, 3));
            s.memRw  = 1'($urandom);
            s.memWr  = RW'($urandom_range(0, 3));
            s.wbRw   = 1'($urandom);
            s.wbWr   = RW'($urandom_range(0, 3));
            drive(s);
        end

        @(negedge clock);
        @(negedge clock);
        check("queue_drain", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
